scan_transfer_buffer: RTL

- Downstream stage for the two Scanner instances.
- Watches each scanner's 3-bit state, accepts data words only from the scanner that holds the transfer grant, and tags each word with its source ID.
- Buffers accepted words in a FIFO toward the host/comm port, using a first-word-fall-through valid/ready interface.
- Arbitrates between scanners, discards words from a flushing scanner, and reports the length of each completed burst.

---
 rtl/scanner_pkg.sv | 23 ++
 rtl/scan_fifo.sv | 62 ++++++
 rtl/scan_transfer_buffer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/scanner_pkg.sv
// scanner_pkg: shared encodings for the scanner transfer path.
// Scanner state codes, source IDs and arbiter state codes.
`default_nettype none

package scanner_pkg;

   localparam logic [2:0] LOWPOWER     = 3'b000;
   localparam logic [2:0] STANDBY      = 3'b001;
   localparam logic [2:0] COLLECTING   = 3'b010;
   localparam logic [2:0] IDLE         = 3'b011;
   localparam logic [2:0] TRANSFERRING = 3'b100;
   localparam logic [2:0] FLUSHING     = 3'b101;

   localparam logic SRC_S0 = 1'b0;
   localparam logic SRC_S1 = 1'b1;

   localparam logic [1:0] ARB_IDLE = 2'd0;
   localparam logic [1:0] ARB_RX0  = 2'd1;
   localparam logic [1:0] ARB_RX1  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/scan_fifo.sv
// scan_fifo: synchronous first-word-fall-through FIFO, power-of-two DEPTH.
// A push while full is accepted only when a pop frees a slot the same cycle.
`default_nettype none

module scan_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_push_ok,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic [CNT_W-1:0] o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_empty;
   logic             w_pop_ok;

   assign w_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign w_pop_ok  = i_pop & ~w_empty;
   assign o_push_ok = i_push & (~o_full | w_pop_ok);
   assign o_valid   = ~w_empty;
   assign o_count   = r_count;
   // Head is forced to zero when empty so the port never shows stale storage.
   assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (o_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({o_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (o_push_ok) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

`default_nettype wire

// File: rtl/scan_transfer_buffer.sv
// scan_transfer_buffer: arbitrates two scanners into a tagged FWFT FIFO.
// Optional SCAN_BUF_DROP_CNT_EN adds a saturating discarded-word counter.
`default_nettype none

module scan_transfer_buffer
   import scanner_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        s0_state,
   input  logic              s0_valid,
   input  logic [DATA_W-1:0] s0_data,
   input  logic [2:0]        s1_state,
   input  logic              s1_valid,
   input  logic [DATA_W-1:0] s1_data,
   input  logic              out_ready,
   input  logic              clr_overflow,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_src,
   output logic [1:0]        grant,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              overflow,
   output logic              xfer_done,
   output logic [CNT_W-1:0]  last_len
`ifdef SCAN_BUF_DROP_CNT_EN
   ,
   output logic [7:0]        drop_cnt
`endif
);

   logic [1:0]        r_arb;
   logic [1:0]        w_arb_nxt;
   logic [1:0]        w_grant;
   logic              w_end;
   logic              w_s0_tx;
   logic              w_s1_tx;
   logic              w_push;
   logic              w_push_ok;
   logic              w_pop;
   logic              w_ovf_evt;
   logic [DATA_W:0]   w_push_word;
   logic [DATA_W:0]   w_head;
   logic [CNT_W-1:0]  r_burst;
   logic [CNT_W-1:0]  r_last_len;
   logic              r_xfer_done;
   logic              r_overflow;

   assign w_s0_tx = (s0_state == TRANSFERRING);
   assign w_s1_tx = (s1_state == TRANSFERRING);

   // In ARB_IDLE the grant follows the inputs so the first word is not lost.
   always_comb begin
      w_arb_nxt = r_arb;
      w_grant   = 2'b00;
      w_end     = 1'b0;
      case (r_arb)
         ARB_IDLE: begin
            if (w_s0_tx) begin
               w_arb_nxt = ARB_RX0;
               w_grant   = 2'b01;
            end else if (w_s1_tx) begin
               w_arb_nxt = ARB_RX1;
               w_grant   = 2'b10;
            end
         end
         ARB_RX0: begin
            w_grant = 2'b01;
            if (!w_s0_tx) begin
               w_arb_nxt = ARB_IDLE;
               w_end     = 1'b1;
            end
         end
         ARB_RX1: begin
            w_grant = 2'b10;
            if (!w_s1_tx) begin
               w_arb_nxt = ARB_IDLE;
               w_end     = 1'b1;
            end
         end
         default: w_arb_nxt = ARB_IDLE;
      endcase
   end

   assign grant       = reset ? w_grant : 2'b00;
   assign w_push      = (grant[0] & s0_valid & w_s0_tx) | (grant[1] & s1_valid & w_s1_tx);
   assign w_push_word = grant[1] ? {SRC_S1, s1_data} : {SRC_S0, s0_data};
   assign w_pop       = out_valid & out_ready;
   assign w_ovf_evt   = w_push & ~w_push_ok;

   scan_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_push    (w_push),
      .i_data    (w_push_word),
      .i_pop     (w_pop),
      .o_push_ok (w_push_ok),
      .o_valid   (out_valid),
      .o_data    (w_head),
      .o_full    (full),
      .o_count   (count)
   );

   assign out_src   = w_head[DATA_W];
   assign out_data  = w_head[DATA_W-1:0];
   assign xfer_done = r_xfer_done;
   assign last_len  = r_last_len;
   assign overflow  = r_overflow;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_arb       <= ARB_IDLE;
         r_burst     <= '0;
         r_last_len  <= '0;
         r_xfer_done <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_arb       <= w_arb_nxt;
         r_xfer_done <= w_end;
         if (w_end) r_last_len <= r_burst;
         // The idle-cycle push is word 1 of the burst being entered.
         if (r_arb == ARB_IDLE)
            r_burst <= w_push_ok ? CNT_W'(1) : '0;
         else if (w_push_ok && (r_burst != '1))
            r_burst <= r_burst + CNT_W'(1);
         if (w_ovf_evt)
            r_overflow <= 1'b1;
         else if (clr_overflow)
            r_overflow <= 1'b0;
      end
   end

`ifdef SCAN_BUF_DROP_CNT_EN
   logic       w_drop;
   logic [7:0] r_drop_cnt;

   assign w_drop = (s0_valid & ((s0_state == FLUSHING) | (w_s0_tx & ~grant[0])))
                 | (s1_valid & ((s1_state == FLUSHING) | (w_s1_tx & ~grant[1])))
                 | w_ovf_evt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_drop_cnt <= '0;
      else if (w_drop)
         r_drop_cnt <= clr_overflow ? 8'd1 : ((r_drop_cnt == 8'hFF) ? r_drop_cnt : r_drop_cnt + 8'd1);
      else if (clr_overflow)
         r_drop_cnt <= '0;
   end

   assign drop_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire
